// File: rtl/median_pkg.sv
// Shared constants and FSM state type for the window serializer feeding the
// 3x3 median stage.
package median_pkg;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_IMG_W = 16;
    localparam int unsigned DEF_IMG_H = 16;
    localparam int unsigned SLOTS     = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_t;

endpackage

// File: rtl/line_buffer.sv
// Single write / single read line memory with a registered read port.
module line_buffer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     CLK,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge CLK) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/window_serializer.sv
// Buffers two image lines and emits every interior 3x3 neighbourhood as nine
// strobed pixels for the median stage, paced by the median's DONE pulse.
module window_serializer
    import median_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned IMG_W = DEF_IMG_W,
    parameter int unsigned IMG_H = DEF_IMG_H
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [WIDTH-1:0] DI,
    input  logic             DVALID,
    input  logic             SOF,
    output logic             DREADY,
    output logic [WIDTH-1:0] DO,
    output logic             DSO,
    input  logic             DONE
);

    localparam int unsigned CW = $clog2(IMG_W);
    localparam int unsigned RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_H - 1);
    localparam logic [3:0]    SLOT_LAST = 4'(SLOTS - 1);

    state_t r_state, w_state_next;

    logic [RW-1:0] r_row, w_row, w_row_next;
    logic [CW-1:0] r_col, w_col, w_col_next, w_raddr;
    logic          w_acc, w_complete;

    logic [2*WIDTH-1:0] w_lb_rdata;
    logic [2:0][2:0][WIDTH-1:0] r_win, w_win;
    logic [SLOTS-1:0][WIDTH-1:0] r_buf, w_buf;
    logic [3:0]       r_slot;
    logic [WIDTH-1:0] r_do;
    logic             r_dso;

    assign w_row      = SOF ? '0 : r_row;
    assign w_col      = SOF ? '0 : r_col;
    assign w_col_next = (w_col == COL_LAST) ? '0 : w_col + CW'(1);
    assign w_row_next = (w_col != COL_LAST) ? w_row :
                        (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    assign w_complete = (w_row >= RW'(2)) && (w_col >= CW'(2));
    assign w_acc      = DVALID && DREADY;

    // Read address runs one column ahead so the registered read already holds
    // the column of the next pixel when it is accepted.
    assign w_raddr = !nRST ? '0 : (w_acc ? w_col_next : r_col);

    // Upper half holds row r-1, lower half row r-2.
    line_buffer #(
        .WIDTH(2 * WIDTH),
        .DEPTH(IMG_W)
    ) u_lines (
        .CLK    (CLK),
        .i_we   (w_acc),
        .i_waddr(w_col),
        .i_wdata({DI, w_lb_rdata[2*WIDTH-1:WIDTH]}),
        .i_raddr(w_raddr),
        .o_rdata(w_lb_rdata)
    );

    always_comb begin
        w_win = r_win;
        for (int unsigned i = 0; i < 3; i++) begin
            w_win[i][0] = r_win[i][1];
            w_win[i][1] = r_win[i][2];
        end
        w_win[0][2] = w_lb_rdata[WIDTH-1:0];
        w_win[1][2] = w_lb_rdata[2*WIDTH-1:WIDTH];
        w_win[2][2] = DI;
    end

    always_comb begin
        w_buf = '0;
        for (int unsigned k = 0; k < SLOTS; k++)
            w_buf[k] = w_win[k / 3][k % 3];
    end

    always_comb begin
        DREADY = 1'b1;
        unique case (r_state)
            SEND:    DREADY = 1'b0;
            WAIT:    DREADY = w_complete ? DONE : 1'b1;
            default: DREADY = 1'b1;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE: if (w_acc && w_complete) w_state_next = SEND;
            SEND: if (r_slot == SLOT_LAST) w_state_next = WAIT;
            WAIT: begin
                if (w_acc && w_complete)
                    w_state_next = SEND;
                else if (DONE)
                    w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST)
            r_state <= IDLE;
        else
            r_state <= w_state_next;
    end

    always_ff @(posedge CLK) begin
        if (w_acc)
            r_win <= w_win;
        if (r_state != SEND && w_acc && w_complete)
            r_buf <= w_buf;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_row  <= '0;
            r_col  <= '0;
            r_slot <= '0;
            r_do   <= '0;
            r_dso  <= 1'b0;
        end else begin
            if (w_acc) begin
                r_row <= w_row_next;
                r_col <= w_col_next;
            end
            if (r_state != SEND) begin
                if (w_acc && w_complete) begin
                    r_do   <= w_win[0][0];
                    r_dso  <= 1'b1;
                    r_slot <= '0;
                end
            end else if (r_slot == SLOT_LAST) begin
                r_dso <= 1'b0;
            end else begin
                r_slot <= r_slot + 4'd1;
                r_do   <= r_buf[r_slot + 4'd1];
            end
        end
    end

    assign DO  = r_do;
    assign DSO = r_dso;

endmodule

// File: tb/tb_window_serializer.sv
// Directed-sequence bench for window_serializer with a frame-image reference
// model: expected windows are read straight out of the stored image.
module tb_window_serializer;

    localparam int unsigned W  = 8;
    localparam int unsigned IW = 4;
    localparam int unsigned IH = 4;

    logic         CLK    = 1'b0;
    logic         nRST   = 1'b0;
    logic         DVALID = 1'b0;
    logic         SOF    = 1'b0;
    logic         DONE   = 1'b0;
    logic [W-1:0] DI     = '0;
    logic         DREADY, DSO;
    logic [W-1:0] DO;

    int   errors = 0;
    int   checks = 0;
    int   m_row = 0, m_col = 0;
    int   win_count = 0;
    bit   aborted = 1'b0;
    logic done_idle = 1'b1;
    logic [W-1:0] img [IH][IW];

    window_serializer #(
        .WIDTH(W),
        .IMG_W(IW),
        .IMG_H(IH)
    ) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .DI    (DI),
        .DVALID(DVALID),
        .SOF   (SOF),
        .DREADY(DREADY),
        .DO    (DO),
        .DSO   (DSO),
        .DONE  (DONE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nRST = 1'b0; DVALID = 1'b0; SOF = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_dso", 32'(DSO), 32'd0);
        check("rst_do", 32'(DO), 32'd0);
        check("rst_dready", 32'(DREADY), 32'd1);
        nRST = 1'b1;
        m_row = 0; m_col = 0;
    endtask

    // Entered at #1 after the edge that accepted the completing pixel (r,c).
    task automatic check_window(input int r, input int c, input int abort_slot);
        for (int k = 0; k < 9; k++) begin
            if (k > 0) begin
                @(posedge CLK);
                #1;
            end
            check("dso_send", 32'(DSO), 32'd1);
            check("dready_send", 32'(DREADY), 32'd0);
            check($sformatf("win(%0d,%0d)[%0d]", r, c, k), 32'(DO),
                  32'(img[r - 2 + k / 3][c - 2 + k % 3]));
            if (k == abort_slot) begin
                nRST = 1'b0;
                @(posedge CLK);
                #1;
                check("dso_after_rst", 32'(DSO), 32'd0);
                check("dready_after_rst", 32'(DREADY), 32'd1);
                nRST = 1'b1;
                m_row = 0; m_col = 0;
                aborted = 1'b1;
                return;
            end
        end
        @(posedge CLK);
        #1;
        check("dso_end", 32'(DSO), 32'd0);
        win_count++;
    endtask

    task automatic send_pixel(input logic [W-1:0] v, input bit sof, input int gap,
                              input int block, input int abort_slot, input bit exp_rdy);
        int r, c;
        bit got;
        repeat (gap) @(negedge CLK);
        @(negedge CLK);
        DI = v; SOF = sof; DVALID = 1'b1;
        if (block > 0) begin
            DONE = 1'b0;
            for (int i = 0; i < block; i++) begin
                #2;
                check("dready_blocked", 32'(DREADY), 32'd0);
                @(negedge CLK);
            end
            DONE = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            #2;
            got = DREADY;
            if (i == 0 && exp_rdy)
                check("dready_open", 32'(DREADY), 32'd1);
            @(posedge CLK);
            #1;
            if (got) break;
            @(negedge CLK);
        end
        check("accept_timeout", 32'(got), 32'd1);
        DVALID = 1'b0; SOF = 1'b0; DONE = done_idle;
        if (sof) begin
            m_row = 0; m_col = 0;
        end
        r = m_row; c = m_col;
        img[r][c] = v;
        m_col = (m_col + 1) % IW;
        if (m_col == 0) m_row = (m_row + 1) % IH;
        if (r >= 2 && c >= 2)
            check_window(r, c, abort_slot);
        else
            check("no_window", 32'(DSO), 32'd0);
    endtask

    task automatic send_frame(input bit rand_data, input bit use_sof, input int max_gap,
                              input int block, input int abort_slot);
        int wc0;
        logic [W-1:0] v;
        bit cmp, first;
        wc0 = win_count;
        aborted = 1'b0;
        for (int r = 0; r < int'(IH); r++) begin
            for (int c = 0; c < int'(IW); c++) begin
                v = rand_data ? W'($urandom) : W'(16 * r + c);
                cmp = (r >= 2 && c >= 2);
                first = (r == 2 && c == 2);
                send_pixel(v, use_sof && r == 0 && c == 0,
                           int'($urandom_range(0, max_gap)),
                           (cmp && !first) ? block : 0,
                           first ? abort_slot : -1,
                           block > 0 && !cmp);
                if (aborted) return;
            end
        end
        check("windows_per_frame", 32'(win_count - wc0), 32'((IW - 2) * (IH - 2)));
    endtask

    initial begin
        do_reset();

        // Frame fill with DONE held high, then the same frame with random gaps.
        done_idle = 1'b1; DONE = 1'b1;
        send_frame(1'b0, 1'b1, 0, 0, -1);
        send_frame(1'b0, 1'b1, 4, 0, -1);

        // Back-to-back frames without SOF: counters must wrap cleanly.
        send_frame(1'b1, 1'b0, 2, 0, -1);
        send_frame(1'b0, 1'b0, 0, 0, -1);
        send_frame(1'b1, 1'b0, 3, 0, -1);

        // Back-pressure: DONE only pulses when a completing pixel is pending.
        do_reset();
        done_idle = 1'b0; DONE = 1'b0;
        send_frame(1'b0, 1'b1, 0, 3, -1);

        // SOF arrives at position (1,2) of a partial frame.
        do_reset();
        done_idle = 1'b1; DONE = 1'b1;
        for (int i = 0; i < 6; i++)
            send_pixel(W'(8'hE0 + i), i == 0, 0, 0, -1, 1'b0);
        send_frame(1'b1, 1'b1, 2, 0, -1);

        // Reset during slot 4 of the first window, then a fresh frame from (0,0).
        do_reset();
        send_frame(1'b0, 1'b1, 0, 0, 4);
        check("abort_taken", 32'(aborted), 32'd1);
        send_frame(1'b0, 1'b0, 0, 0, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/window_serializer.md
Name: window_serializer

Overview:
- Upstream feeder for the 3x3 median filter stage.
- Accepts a raster-order pixel stream through a valid/ready handshake and buffers two image lines.
- For every interior pixel position, emits the 3x3 neighbourhood as 9 consecutive pixels with a strobe (DSO), which is the serial window format the median stage consumes on DI/DSI.
- Uses the median stage's completion pulse to pace windows.

Parameters:
- WIDTH, 8, pixel width in bits
- IMG_W, 16, image width in pixels (>=3)
- IMG_H, 16, image height in lines (>=3)

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, synchronous, active-low
- DI  in  WIDTH  input pixel, raster order
- DVALID  in  1  DI valid
- SOF  in  1  start of frame; qualifies the pixel accepted in the same cycle
- DREADY  out  1  block can accept DI this cycle
- DO  out  WIDTH  serialized window pixel (to median DI)
- DSO  out  1  window strobe, high 9 consecutive cycles per window (to median DSI)
- DONE  in  1  median result pulse (from median DSO)

Behaviour:
- Clock and reset: reset nRST, synchronous, active-low; clock CLK.
- Reset values: DREADY=1, DO=0, DSO=0, row=0, col=0, state=IDLE, slot counter=0. Line-buffer contents are not cleared.
- Accept: a pixel is accepted when DVALID&&DREADY at a CLK edge.
- Coordinates:
  - SOF=1 on the accepted pixel forces its coordinates to (0,0); otherwise it takes the current (row,col).
  - After acceptance, col increments; at IMG_W-1 it wraps to 0 and row increments; row wraps to 0 after IMG_H-1.
  - SOF mid-frame discards the partial frame; no window that needs pre-SOF rows is emitted.
- Storage:
  - Two line buffers hold rows r-1 and r-2.
  - A 3x3 register window shifts one column per accepted pixel.
- Window trigger:
  - An accepted pixel at (r,c) with r>=2 and c>=2 completes the window centred at (r-1,c-1).
  - Border pixels never produce windows; output is (IMG_W-2)*(IMG_H-2) windows per frame.
- FSM states:
  - IDLE: DREADY=1.
    - Completing pixel accepted -> SEND, with the slot counter cleared and the 9 window pixels latched.
  - SEND: DREADY=0, DSO=1 for exactly 9 cycles.
    - Slot k=0..8 drives DO in row-major order, top-left first: (r-2,c-2),(r-2,c-1),(r-2,c),(r-1,c-2)..(r,c).
    - After slot 8 -> WAIT.
  - WAIT:
    - DREADY=1 for non-completing pixel positions.
    - For a completing position, DREADY=DONE; that pixel is accepted only in a cycle where DONE=1, then -> SEND.
    - DONE=1 with no completing pixel accepted -> IDLE.
- Latency: completing pixel accepted at edge t -> DSO high and DO valid on cycles t+1..t+9. DO and DSO are registered.
- DONE outside WAIT is ignored.
- DO holds its last value while DSO=0.
- Simultaneous DONE and completing pixel in WAIT: accept the pixel and go to SEND; the median stage restarts cleanly because its DSI arrives one cycle after DONE.
- nRST low mid-SEND: DSO drops on the next edge, the partial window is abandoned, and the next frame must begin with SOF or at (0,0).

Decomposition:
- Package median_pkg:
  - FSM state enum (IDLE/SEND/WAIT).
  - Default WIDTH/IMG_W/IMG_H constants.
  - Slot-count constant 9.
- Sub-module line_buffer: 1 write/1 read port, depth IMG_W, WIDTH bits, registered read. Instantiated twice, or once as a 2*WIDTH-wide buffer.
- The top level holds the coordinate counters, 3x3 window, FSM and output mux.

Test Plan:
- Frame fill, IMG_W=IMG_H=4, pixel=16*r+c, DONE held 1 -> after pixel 0x22, DO=00,01,02,10,11,12,20,21,22 with DSO high 9 cycles; 4 windows per frame total.
- Back-pressure: DONE never pulsed after the first window -> DREADY low when pixel (2,3) is presented and high for (3,0)/(3,1); pulse DONE -> pixel 0x23 accepted that cycle, window 01,02,03,11,12,13,21,22,23 follows.
- DVALID gaps of random length between pixels -> identical window contents and order versus the gap-free run.
- SOF mid-frame at (1,2) -> no window until row 2, col 2 of the new frame; the first window contains only post-SOF data.
- nRST asserted on slot 4 of SEND -> next-cycle DSO=0, DREADY=1, coordinates (0,0); a fresh frame reproduces the window of scenario 1.
- Two consecutive frames without SOF -> counters wrap and frame 2 windows match frame 1 given the same data.
